// File: rtl/cnt_seq_monitor.sv
// Sequence monitor for a free-running up counter.
// Ports: clk, rst (async active-low), cnt_in, clr, match_val -> tc_pulse,
//        match_pulse, wrap_cnt, wrap_ovf, ext_cnt, seq_err, err_val, state.
module cnt_seq_monitor #(
  parameter int WIDTH  = 4,
  parameter int WRAP_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [WIDTH-1:0]        cnt_in,
  input  logic                    clr,
  input  logic [WIDTH-1:0]        match_val,
  output logic                    tc_pulse,
  output logic                    match_pulse,
  output logic [WRAP_W-1:0]       wrap_cnt,
  output logic                    wrap_ovf,
  output logic [WRAP_W+WIDTH-1:0] ext_cnt,
  output logic                    seq_err,
  output logic [WIDTH-1:0]        err_val,
  output logic [1:0]              state
);

  localparam logic [1:0] SYNC  = 2'b00;
  localparam logic [1:0] TRACK = 2'b01;
  localparam logic [1:0] FAULT = 2'b10;

  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0]  prev;
  logic [WIDTH-1:0]  exp_cnt;
  logic              in_seq;
  logic              wrap;
  logic              hit;
  logic [WRAP_W-1:0] wrap_nxt;

  assign exp_cnt  = prev + WIDTH'(1);
  assign in_seq   = (cnt_in == exp_cnt);
  // in_seq with prev at max already implies cnt_in == 0
  assign wrap     = (state == TRACK) && in_seq
                    && (prev == CNT_MAX);
  assign wrap_nxt = wrap_cnt + WRAP_W'(wrap);
  assign hit      = (cnt_in == match_val);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= SYNC;
      prev        <= '0;
      wrap_cnt    <= '0;
      wrap_ovf    <= 1'b0;
      ext_cnt     <= '0;
      seq_err     <= 1'b0;
      err_val     <= '0;
      tc_pulse    <= 1'b0;
      match_pulse <= 1'b0;
    end else if (clr) begin
      state       <= SYNC;
      prev        <= cnt_in;
      wrap_cnt    <= '0;
      wrap_ovf    <= 1'b0;
      ext_cnt     <= {{WRAP_W{1'b0}}, cnt_in};
      seq_err     <= 1'b0;
      err_val     <= '0;
      tc_pulse    <= 1'b0;
      match_pulse <= 1'b0;
    end else begin
      unique case (1'b1)
        (state == SYNC): begin
          prev        <= cnt_in;
          tc_pulse    <= 1'b0;
          match_pulse <= hit;
          ext_cnt     <= {wrap_cnt, cnt_in};
          state       <= TRACK;
        end
        (state == TRACK): begin
          prev        <= cnt_in;
          tc_pulse    <= wrap;
          match_pulse <= hit;
          ext_cnt     <= {wrap_nxt, cnt_in};
          wrap_cnt    <= wrap_nxt;
          if (wrap && (&wrap_cnt))
            wrap_ovf <= 1'b1;
          if (!in_seq) begin
            seq_err <= 1'b1;
            err_val <= cnt_in;
            state   <= FAULT;
          end
        end
        (state == FAULT): begin
          prev        <= cnt_in;
          tc_pulse    <= 1'b0;
          match_pulse <= 1'b0;
        end
        default: begin
          state       <= SYNC;
          tc_pulse    <= 1'b0;
          match_pulse <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cnt_seq_monitor.sv
// Scoreboard bench for cnt_seq_monitor.
// Driver pushes model results; monitor pops and compares each cycle.
module tb_cnt_seq_monitor;

  logic        clk;
  logic        rst;
  logic [3:0]  cnt_in;
  logic        clr;
  logic [3:0]  match_val;
  logic        tc_pulse;
  logic        match_pulse;
  logic [7:0]  wrap_cnt;
  logic        wrap_ovf;
  logic [11:0] ext_cnt;
  logic        seq_err;
  logic [3:0]  err_val;
  logic [1:0]  state;

  cnt_seq_monitor #(.WIDTH(4), .WRAP_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .cnt_in      (cnt_in),
    .clr         (clr),
    .match_val   (match_val),
    .tc_pulse    (tc_pulse),
    .match_pulse (match_pulse),
    .wrap_cnt    (wrap_cnt),
    .wrap_ovf    (wrap_ovf),
    .ext_cnt     (ext_cnt),
    .seq_err     (seq_err),
    .err_val     (err_val),
    .state       (state)
  );

  typedef struct packed {
    logic        tc;
    logic        mt;
    logic [7:0]  wc;
    logic        ovf;
    logic [11:0] ext;
    logic        err;
    logic [3:0]  ev;
    logic [1:0]  st;
  } obs_t;

  obs_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   pushes = 0;
  int   pops   = 0;

  // reference model: mode 0 = waiting for first sample,
  // 1 = checking, 2 = faulted
  int m_mode, m_prev, m_wraps, m_err, m_errv, m_tc, m_mt, m_ext;
  int c;
  logic [3:0] mv;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic obs_t snap();
    obs_t o;
    o.tc  = tc_pulse;
    o.mt  = match_pulse;
    o.wc  = wrap_cnt;
    o.ovf = wrap_ovf;
    o.ext = ext_cnt;
    o.err = seq_err;
    o.ev  = err_val;
    o.st  = state;
    return o;
  endfunction

  task automatic check(input string nm, input obs_t a, input obs_t e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s t=%0t got tc=%b mt=%b wc=%0d ovf=%b ext=%h err=%b ev=%h st=%b want tc=%b mt=%b wc=%0d ovf=%b ext=%h err=%b ev=%h st=%b",
        nm, $time, a.tc, a.mt, a.wc, a.ovf, a.ext, a.err, a.ev, a.st,
        e.tc, e.mt, e.wc, e.ovf, e.ext, e.err, e.ev, e.st);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_prev = 0; m_wraps = 0; m_err = 0;
    m_errv = 0; m_tc = 0; m_mt = 0; m_ext = 0;
  endtask

  task automatic model_step(input int v, input bit cl, input int mval);
    if (!rst) begin
      model_reset();
    end else if (cl) begin
      model_reset();
      m_prev = v;
      m_ext  = v;
    end else if (m_mode == 0) begin
      m_prev = v;
      m_tc   = 0;
      m_mt   = (v == mval);
      m_ext  = (m_wraps % 256) * 16 + v;
      m_mode = 1;
    end else if (m_mode == 1) begin
      if (v == (m_prev + 1) % 16) begin
        m_tc    = (v == 0);
        m_wraps = m_wraps + m_tc;
      end else begin
        m_tc   = 0;
        m_err  = 1;
        m_errv = v;
        m_mode = 2;
      end
      m_prev = v;
      m_mt   = (v == mval);
      m_ext  = (m_wraps % 256) * 16 + v;
    end else begin
      m_prev = v;
      m_tc   = 0;
      m_mt   = 0;
    end
  endtask

  function automatic obs_t model_out();
    obs_t o;
    o.tc  = m_tc[0];
    o.mt  = m_mt[0];
    o.wc  = 8'(m_wraps % 256);
    o.ovf = (m_wraps >= 256);
    o.ext = 12'(m_ext);
    o.err = m_err[0];
    o.ev  = 4'(m_errv);
    o.st  = 2'(m_mode);
    return o;
  endfunction

  task automatic drive(input int v, input bit cl, input bit r);
    @(negedge clk);
    rst       = r;
    cnt_in    = 4'(v);
    clr       = cl;
    match_val = mv;
    model_step(v, cl, int'(mv));
    sb.push_back(model_out());
    pushes++;
  endtask

  task automatic count(input int n);
    repeat (n) begin
      c = (c + 1) % 16;
      drive(c, 1'b0, 1'b1);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      obs_t e;
      e = sb.pop_front();
      pops++;
      check("cycle", snap(), e);
    end
  end

  initial begin
    rst = 1'b0; cnt_in = '0; clr = 1'b0; match_val = '0;
    mv = 4'hA;
    model_reset();
    c = 0;

    // reset held three cycles
    repeat (3) drive(int'($urandom_range(0, 15)), 1'b0, 1'b0);

    // plain counting with match on A, then on 3
    c = 0;
    drive(c, 1'b0, 1'b1);
    count(39);
    count(20);
    mv = 4'h3;
    count(30);

    // violation ...5,6,8 then recovery via clr
    c = 0;
    drive(c, 1'b1, 1'b1);
    count(6);
    c = 8;
    drive(c, 1'b0, 1'b1);
    count(16);
    c = (c + 1) % 16;
    drive(c, 1'b1, 1'b1);
    count(20);

    // repeated max and stall
    c = 0;
    drive(c, 1'b1, 1'b1);
    count(15);
    drive(c, 1'b0, 1'b1);
    c = 0;
    drive(c, 1'b1, 1'b1);
    count(3);
    drive(c, 1'b0, 1'b1);

    // wrap counter overflow: 261 wraps
    c = 0;
    drive(c, 1'b1, 1'b1);
    count(261 * 16);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      int r;
      r = int'($urandom_range(0, 63));
      if (r < 2) mv = 4'($urandom_range(0, 15));
      if (r == 63) begin
        drive(c, 1'b1, 1'b1);
      end else if (r < 4) begin
        c = int'($urandom_range(0, 15));
        drive(c, 1'b0, 1'b1);
      end else begin
        count(1);
      end
    end

    // seven wraps, a fault, then async reset between edges
    c = 0;
    drive(c, 1'b1, 1'b1);
    count(7 * 16 + 2);
    c = (c + 2) % 16;
    drive(c, 1'b0, 1'b1);
    count(3);
    @(posedge clk);
    #3;
    rst = 1'b0;
    model_reset();
    #1;
    check("async_rst", snap(), model_out());

    // clr and rst together resolve to reset
    drive(c, 1'b1, 1'b0);
    drive(c, 1'b1, 1'b0);
    c = 0;
    drive(c, 1'b0, 1'b1);
    count(20);

    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    total++;
    if (pops != pushes || sb.size() != 0) begin
      bad++;
      $display("FAIL drain popped=%0d pushed=%0d", pops, pushes);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
